// File: rtl/multisim_qs_pkg.sv
// Shared types and constants for the quasi-static pull client.
//   qs_state_e  : replay FSM states (QS_IDLE, QS_HOLD)
//   HOLD_CNT_W  : width of the minimum-hold counter
package multisim_qs_pkg;

  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic [0:0] {
    QS_IDLE = 1'b0,
    QS_HOLD = 1'b1
  } qs_state_e;

endpackage

// File: rtl/multisim_qs_fifo.sv
// Small synchronous FIFO buffering value updates ahead of the replay FSM.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   o_head     : entry at the read pointer
//   o_full     : occupancy equals DEPTH
//   o_empty    : occupancy is zero
//   o_level    : current occupancy, 0..DEPTH
module multisim_qs_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_full;
  logic                  r_empty;
  logic [LW-1:0]         w_level_nxt;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Storage needs no reset; occupancy flags gate every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/multisim_client_quasi_static_pull.sv
// Receive side of the quasi-static channel: buffers value updates from a
// valid/ready stream and replays them onto a held output bus, keeping each
// value for at least MIN_HOLD+1 cycles.
// Optional feature macro: MULTISIM_QS_DEDUP_EN (drop words equal to the
// previously accepted word).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   in_vld      : upstream word valid
//   in_rdy      : block can accept a word (FIFO not full)
//   in_data     : upstream word
//   data        : quasi-static held value
//   data_upd    : one-cycle pulse when data takes a new FIFO word
//   fifo_level  : current FIFO occupancy
module multisim_client_quasi_static_pull
  import multisim_qs_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 64,
  parameter int unsigned          DEPTH       = 4,
  parameter int unsigned          MIN_HOLD    = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    data_upd,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  qs_state_e              r_state;
  logic [HOLD_CNT_W-1:0]  r_hold_cnt;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_data_upd;

  logic                   w_accept;
  logic                   w_write;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_WIDTH-1:0]  w_head;
  logic [$clog2(DEPTH):0] w_level;

  assign w_accept = in_vld && in_rdy;

`ifdef MULTISIM_QS_DEDUP_EN
  // Last accepted word; repeats complete the handshake but are not stored.
  logic [DATA_WIDTH-1:0] r_last;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_last <= RESET_VALUE;
    else if (w_accept) r_last <= in_data;
  end

  assign w_write = w_accept && (in_data != r_last);
`else
  assign w_write = w_accept;
`endif

  // Pop only from IDLE; the head is captured into data on the same edge.
  assign w_pop = (r_state == QS_IDLE) && !w_empty;

  multisim_qs_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_write),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Replay FSM: IDLE pops and updates, HOLD counts down the minimum hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= QS_IDLE;
      r_hold_cnt <= '0;
      r_data     <= RESET_VALUE;
      r_data_upd <= 1'b0;
    end else begin
      r_data_upd <= 1'b0;
      case (r_state)
        QS_IDLE: begin
          if (!w_empty) begin
            r_data     <= w_head;
            r_data_upd <= 1'b1;
            r_hold_cnt <= HOLD_CNT_W'(MIN_HOLD);
            r_state    <= (MIN_HOLD != 0) ? QS_HOLD : QS_IDLE;
          end
        end
        QS_HOLD: begin
          if (r_hold_cnt == HOLD_CNT_W'(1)) begin
            r_hold_cnt <= '0;
            r_state    <= QS_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_CNT_W'(1);
          end
        end
        default: r_state <= QS_IDLE;
      endcase
    end
  end

  // Ready depends only on registered occupancy, never on in_vld.
  assign in_rdy     = !w_full;
  assign data       = r_data;
  assign data_upd   = r_data_upd;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_multisim_client_quasi_static_pull.sv
// Bench for multisim_client_quasi_static_pull: three instances with
// MIN_HOLD 0, 2 and 10 checked every cycle against a queue-based model.
module tb_multisim_client_quasi_static_pull;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RV    = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       vld  [3];
  logic [7:0] din  [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic       upd  [3];
  logic [2:0] lvl  [3];

  multisim_client_quasi_static_pull #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MIN_HOLD(0), .RESET_VALUE(RV)) u0 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld[0]), .in_rdy(rdy[0]), .in_data(din[0]),
    .data(dout[0]), .data_upd(upd[0]), .fifo_level(lvl[0]));
  multisim_client_quasi_static_pull #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MIN_HOLD(2), .RESET_VALUE(RV)) u1 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld[1]), .in_rdy(rdy[1]), .in_data(din[1]),
    .data(dout[1]), .data_upd(upd[1]), .fifo_level(lvl[1]));
  multisim_client_quasi_static_pull #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MIN_HOLD(10), .RESET_VALUE(RV)) u2 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld[2]), .in_rdy(rdy[2]), .in_data(din[2]),
    .data(dout[2]), .data_upd(upd[2]), .fifo_level(lvl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, a queue of buffered words, the held value,
  // and the edge of the last output change.
  longint     mh       [3];
  logic [7:0] mq       [3][$];
  logic [7:0] m_data   [3];
  logic       m_upd    [3];
  bit         m_seen   [3];
  longint     m_tlast  [3];
  logic [7:0] m_last   [3];
  bit         acc      [3];
  // Upstream source queues and observation logs.
  logic [7:0] src      [3][$];
  logic [7:0] obs_log  [3][$];
  longint     upd_edge [3][$];
  longint     acc_edge [3][$];
  int         pulses   [3];
  int         n_tests;
  int         n_fail;
  longint     ncyc;
  longint     t0;
  bit         gaps;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer the next source word; a word stays on the bus until accepted.
  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && acc[i]) begin
        void'(src[i].pop_front());
        vld[i] = 1'b0;
      end
      acc[i] = 1'b0;
      if (!vld[i] && rst_n && src[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        vld[i] = 1'b1;
        din[i] = src[i][0];
      end
    end
  endtask

  // One clock edge: advance the model, compare all outputs, drive next inputs.
  task automatic cycle();
    @(posedge clk);
    ncyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        m_data[i] = RV;
        m_upd[i]  = 1'b0;
        m_seen[i] = 1'b0;
        m_last[i] = RV;
        acc[i]    = 1'b0;
      end else begin
        acc[i]   = vld[i] && (mq[i].size() < int'(DEPTH));
        m_upd[i] = 1'b0;
        if (mq[i].size() > 0 && (!m_seen[i] || ncyc >= m_tlast[i] + mh[i] + 1)) begin
          m_data[i]  = mq[i].pop_front();
          m_upd[i]   = 1'b1;
          m_seen[i]  = 1'b1;
          m_tlast[i] = ncyc;
        end
        if (acc[i]) begin
          acc_edge[i].push_back(ncyc);
`ifdef MULTISIM_QS_DEDUP_EN
          if (din[i] != m_last[i]) mq[i].push_back(din[i]);
`else
          mq[i].push_back(din[i]);
`endif
          m_last[i] = din[i];
        end
      end
      chk($sformatf("data[%0d]@%0d", i, ncyc), dout[i], m_data[i]);
      chk($sformatf("data_upd[%0d]@%0d", i, ncyc), 8'(upd[i]), 8'(m_upd[i]));
      chk($sformatf("fifo_level[%0d]@%0d", i, ncyc), 8'(lvl[i]), 8'(mq[i].size()));
      chk($sformatf("in_rdy[%0d]@%0d", i, ncyc), 8'(rdy[i]), 8'(mq[i].size() < int'(DEPTH)));
      if (upd[i] === 1'b1) begin
        pulses[i]++;
        obs_log[i].push_back(dout[i]);
        upd_edge[i].push_back(ncyc);
      end
    end
    drive();
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      obs_log[i].delete();
      upd_edge[i].delete();
      acc_edge[i].delete();
      pulses[i] = 0;
    end
  endtask

  initial begin
    mh      = '{0, 2, 10};
    n_tests = 0;
    n_fail  = 0;
    ncyc    = 0;
    gaps    = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; din[i] = '0; acc[i] = 1'b0;
      m_data[i] = RV; m_upd[i] = 1'b0; m_seen[i] = 1'b0; m_tlast[i] = 0; m_last[i] = RV;
    end
    clear_logs();

    // Reset state.
    repeat (2) cycle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_data[%0d]", i), dout[i], 8'hA5);
      chk($sformatf("rst_upd[%0d]", i), 8'(upd[i]), 8'h00);
      chk($sformatf("rst_rdy[%0d]", i), 8'(rdy[i]), 8'h01);
      chk($sformatf("rst_lvl[%0d]", i), 8'(lvl[i]), 8'h00);
    end
    rst_n = 1'b1;

    // Single word, accepted in the first cycle out of reset.
    for (int i = 0; i < 3; i++) src[i].push_back(8'h11);
    drive();
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("single_data[%0d]", i), dout[i], 8'h11);
      chk($sformatf("single_upd[%0d]", i), 8'(upd[i]), 8'h01);
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("single_upd_low[%0d]", i), 8'(upd[i]), 8'h00);
      chk($sformatf("single_lvl[%0d]", i), 8'(lvl[i]), 8'h00);
    end
    repeat (12) cycle();

    // Back-to-back 1,2,3: MIN_HOLD=2 instance updates at t+1, t+4, t+7.
    clear_logs();
    for (int i = 0; i < 3; i++) for (int w = 1; w <= 3; w++) src[i].push_back(8'(w));
    drive();
    t0 = ncyc + 1;
    repeat (40) cycle();
    chk("b2b_count", 8'(upd_edge[1].size()), 8'd3);
    if (upd_edge[1].size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("b2b_edge%0d", k), 8'(upd_edge[1][k] - t0), 8'(1 + 3 * k));
        chk($sformatf("b2b_data%0d", k), obs_log[1][k], 8'(k + 1));
      end
    end

    // Full FIFO with MIN_HOLD=10: word 6 waits for a pop at t+12, accepted t+13.
    clear_logs();
    for (int i = 0; i < 3; i++) for (int w = 0; w < 6; w++) src[i].push_back(8'(8'h21 + w));
    drive();
    t0 = ncyc + 1;
    repeat (80) cycle();
    chk("full_acc_count", 8'(acc_edge[2].size()), 8'd6);
    if (acc_edge[2].size() == 6) chk("full_w6_accept", 8'(acc_edge[2][5] - t0), 8'd13);
    if (upd_edge[2].size() >= 2) chk("full_pop2_edge", 8'(upd_edge[2][1] - t0), 8'd12);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("full_out_count[%0d]", i), 8'(obs_log[i].size()), 8'd6);
      if (obs_log[i].size() == 6)
        for (int w = 0; w < 6; w++)
          chk($sformatf("full_order[%0d][%0d]", i, w), obs_log[i][w], 8'(8'h21 + w));
    end

    // Duplicate words 5,5,7,7,5.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      src[i].push_back(8'h05); src[i].push_back(8'h05); src[i].push_back(8'h07);
      src[i].push_back(8'h07); src[i].push_back(8'h05);
    end
    drive();
    repeat (70) cycle();
    for (int i = 0; i < 3; i++) begin
`ifdef MULTISIM_QS_DEDUP_EN
      chk($sformatf("dup_pulses[%0d]", i), 8'(pulses[i]), 8'd3);
`else
      chk($sformatf("dup_pulses[%0d]", i), 8'(pulses[i]), 8'd5);
`endif
    end

    // Reset with three words buffered in the MIN_HOLD=10 instance.
    for (int i = 0; i < 3; i++) for (int w = 0; w < 4; w++) src[i].push_back(8'(8'h31 + w));
    drive();
    repeat (5) cycle();
    chk("midrst_lvl_before", 8'(lvl[2]), 8'd3);
    for (int i = 0; i < 3; i++) begin
      src[i].delete();
      vld[i] = 1'b0;
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_lvl[%0d]", i), 8'(lvl[i]), 8'd0);
      chk($sformatf("midrst_data[%0d]", i), dout[i], 8'hA5);
    end
    clear_logs();
    repeat (25) cycle();
    for (int i = 0; i < 3; i++) chk($sformatf("midrst_no_upd[%0d]", i), 8'(pulses[i]), 8'd0);

    // Randomized traffic with bursts, gaps and frequent repeats.
    gaps = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++)
        if (src[i].size() < 6 && $urandom_range(0, 1) == 1)
          src[i].push_back(8'($urandom_range(0, 3)));
      cycle();
    end
    repeat (120) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
